// File: rtl/score_display_pkg.sv
// Shared types and constants for the score digit drawer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package score_display_pkg;

    localparam int MAX_DIGITS = 8;

    typedef logic [3:0] glyph_t;

    // Glyph slot 10 in the ROM is an empty cell, used for blanked digits.
    localparam glyph_t GLYPH_BLANK = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/score_display_bitmap_if.sv
// Score source + pixel bus bundle for the score drawer.
// Latency: n/a (wires only).
// Backpressure: none; score_valid is a strobe, busy is advisory.
// master = game logic / VGA timing side, slave = score_display_bitmap.
interface score_display_bitmap_if #(
    parameter int SCORE_W = 20
);
    logic [10:0]        pixelX;
    logic [10:0]        pixelY;
    logic [10:0]        topLeftX;
    logic [10:0]        topLeftY;
    logic               startOfFrame;
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               blank_leading_zeros;
    logic               blink_en;
    logic               busy;
    logic               drawingRequest;
    logic [7:0]         RGBout;

    modport master (
        output pixelX, pixelY, topLeftX, topLeftY, startOfFrame,
        output score, score_valid, blank_leading_zeros, blink_en,
        input  busy, drawingRequest, RGBout
    );

    modport slave (
        input  pixelX, pixelY, topLeftX, topLeftY, startOfFrame,
        input  score, score_valid, blank_leading_zeros, blink_en,
        output busy, drawingRequest, RGBout
    );
endinterface

// File: rtl/digit_glyph_rom.sv
// 16x32 seven-segment style glyph ROM: glyphs 0-9 plus blank (10..15).
// Latency: combinational; the caller registers the result.
// Backpressure: none.
// Ports: i_glyph (glyph index), i_row (0..31), i_col (0..15), o_pixel (lit bit).
module digit_glyph_rom
    import score_display_pkg::*;
(
    input  glyph_t     i_glyph,
    input  logic [4:0] i_row,
    input  logic [3:0] i_col,
    output logic       o_pixel
);
    // Segment order: bit0=a(top) b c d(bottom) e f bit6=g(middle).
    logic [6:0] w_seg;
    logic       w_hcols, w_left, w_right, w_upper, w_lower, w_top, w_mid, w_bot;

    always_comb begin
        case (i_glyph)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
    end

    // Columns 0-1 and 14-15 stay dark so neighbouring digits are separated.
    assign w_hcols = (i_col >= 4'd2)  && (i_col <= 4'd13);
    assign w_left  = (i_col >= 4'd2)  && (i_col <= 4'd4);
    assign w_right = (i_col >= 4'd11) && (i_col <= 4'd13);
    assign w_upper = (i_row <= 5'd17);
    assign w_lower = (i_row >= 5'd14);
    assign w_top   = (i_row <= 5'd3);
    assign w_mid   = (i_row >= 5'd14) && (i_row <= 5'd17);
    assign w_bot   = (i_row >= 5'd28);

    assign o_pixel = (w_seg[0] & w_top   & w_hcols) |
                     (w_seg[1] & w_right & w_upper) |
                     (w_seg[2] & w_right & w_lower) |
                     (w_seg[3] & w_bot   & w_hcols) |
                     (w_seg[4] & w_left  & w_lower) |
                     (w_seg[5] & w_left  & w_upper) |
                     (w_seg[6] & w_mid   & w_hcols);
endmodule

// File: rtl/score_display_bitmap.sv
// N-digit decimal score drawer: binary score -> BCD (double dabble), frame-synchronous swap.
// Latency: score_valid -> shadow ready SCORE_W+2 clk (2 if saturated); pixel -> drawingRequest 1 clk.
// Backpressure: none; strobes while converting land in a one-deep pending slot (last wins), busy flags it.
// Ports: clk, resetN (async active-low), bus (slave: pixel coords, score load, busy, draw request, colour).
module score_display_bitmap
    import score_display_pkg::*;
#(
    parameter int         NUM_DIGITS   = 6,
    parameter int         SCORE_W      = 20,
    parameter int         DIGIT_W      = 16,
    parameter int         DIGIT_H      = 32,
    parameter logic [7:0] DIGIT_COLOR  = 8'hFF,
    parameter int         BLINK_FRAMES = 30
)(
    input  logic                  clk,
    input  logic                  resetN,
    score_display_bitmap_if.slave bus
);
    localparam int BCD_W   = NUM_DIGITS * 4;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int COL_W   = $clog2(DIGIT_W);
    localparam int IDX_W   = $clog2(MAX_DIGITS);
    localparam int FC_W    = $clog2(BLINK_FRAMES + 1);
    localparam int FIELD_W = NUM_DIGITS * DIGIT_W;
    localparam logic [63:0]      MAX_SCORE = max_value(NUM_DIGITS);
    localparam logic [BCD_W-1:0] NINES     = {NUM_DIGITS{4'h9}};

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [BCD_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_shadow;
    logic               r_shadow_rdy;
    logic [BCD_W-1:0]   r_disp;
    logic               r_pend_vld;
    logic [SCORE_W-1:0] r_pend_val;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_blink_on;
    logic               r_draw;

    logic [SCORE_W-1:0] w_src;
    logic               w_sat;
    logic [BCD_W-1:0]   w_adj;

    // A waiting pending value always goes before a fresh strobe.
    assign w_src = r_pend_vld ? r_pend_val : bus.score;
    assign w_sat = (64'(w_src) > MAX_SCORE);

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_acc[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= IDLE;
            r_score      <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_shadow_rdy <= 1'b0;
            r_disp       <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_val   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pend_vld || bus.score_valid) begin
                        r_score <= w_src;
                        r_cnt   <= '0;
                        if (w_sat) begin
                            r_acc   <= NINES;
                            r_state <= DONE;
                        end else begin
                            r_acc   <= '0;
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Top bit of the corrected accumulator is always 0 for in-range scores.
                    r_acc   <= BCD_W'({w_adj, r_score[SCORE_W-1]});
                    r_score <= r_score << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_shadow <= r_acc;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (bus.score_valid && ((r_state != IDLE) || r_pend_vld)) begin
                r_pend_vld <= 1'b1;
                r_pend_val <= bus.score;
            end else if ((r_state == IDLE) && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            // A frame start coinciding with DONE shows the previous shadow;
            // the fresh one stays ready for the following frame.
            if (bus.startOfFrame && r_shadow_rdy) begin
                r_disp <= r_shadow;
            end
            if (r_state == DONE) begin
                r_shadow_rdy <= 1'b1;
            end else if (bus.startOfFrame) begin
                r_shadow_rdy <= 1'b0;
            end
        end
    end

    assign bus.busy   = (r_state != IDLE) | r_pend_vld;
    assign bus.RGBout = DIGIT_COLOR;

    // Pixel path
    logic             w_ge, w_inside, w_seen, w_pix;
    logic [10:0]      w_dx, w_dy;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_digit;
    glyph_t           w_glyph;

    assign w_ge     = (bus.pixelX >= bus.topLeftX) && (bus.pixelY >= bus.topLeftY);
    assign w_dx     = bus.pixelX - bus.topLeftX;
    assign w_dy     = bus.pixelY - bus.topLeftY;
    assign w_inside = w_ge && (w_dx < 11'(FIELD_W)) && (w_dy < 11'(DIGIT_H));
    assign w_idx    = w_dx[COL_W +: IDX_W];

    // w_seen accumulates "a nonzero digit exists at or left of i".
    always_comb begin
        w_seen  = 1'b0;
        w_digit = 4'd0;
        w_glyph = GLYPH_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit = r_disp[(NUM_DIGITS-1-i)*4 +: 4];
            w_seen  = w_seen | (w_digit != 4'd0);
            if (w_idx == IDX_W'(i)) begin
                w_glyph = (bus.blank_leading_zeros && !w_seen && (i != NUM_DIGITS-1))
                          ? GLYPH_BLANK : w_digit;
            end
        end
    end

    digit_glyph_rom u_rom (
        .i_glyph (w_glyph),
        .i_row   (w_dy[4:0]),
        .i_col   (w_dx[3:0]),
        .o_pixel (w_pix)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_draw      <= 1'b0;
        end else begin
            if (bus.startOfFrame) begin
                if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            r_draw <= w_inside && w_pix && !(bus.blink_en && !r_blink_on);
        end
    end

    assign bus.drawingRequest = r_draw;
endmodule

// File: tb/tb_score_display_bitmap.sv
// Directed bench for score_display_bitmap: conversion, saturation, pending, blanking, blink, bounds.
// Latency: n/a.
// Backpressure: n/a.
module tb_score_display_bitmap;
    localparam int ND = 6;
    localparam int SW = 20;
    localparam int DW = 16;
    localparam int DH = 32;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    score_display_bitmap_if #(.SCORE_W(SW)) bus ();

    score_display_bitmap #(
        .NUM_DIGITS(ND), .SCORE_W(SW), .DIGIT_W(DW), .DIGIT_H(DH),
        .DIGIT_COLOR(8'hFF), .BLINK_FRAMES(BF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state
    int  m_disp[ND];
    int  m_shadow[ND];
    bit  m_rdy;
    int  m_frames;
    int  tlx, tly;
    bit  m_blank, m_blink;
    int  conv_q[$];
    bit  exp_q[$];

    // Lit segments per glyph; glyph 10 is blank.
    string SEGS[11] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", ""};
    // Probe points hitting segments a,b,c,d,e,f,g and one inter-digit gap column.
    int PCX[8] = '{7, 12, 12, 7, 3, 3, 7, 0};
    int PCY[8] = '{1, 8, 22, 30, 22, 8, 15, 15};

    function automatic bit glyph_px(int g, int c, int r);
        string s;
        bit on;
        s  = SEGS[g];
        on = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": on |= (c >= 2 && c <= 13 && r <= 3);
                "b": on |= (c >= 11 && c <= 13 && r <= 17);
                "c": on |= (c >= 11 && c <= 13 && r >= 14);
                "d": on |= (c >= 2 && c <= 13 && r >= 28);
                "e": on |= (c >= 2 && c <= 4 && r >= 14);
                "f": on |= (c >= 2 && c <= 4 && r <= 17);
                "g": on |= (c >= 2 && c <= 13 && r >= 14 && r <= 17);
                default: on |= 1'b0;
            endcase
        end
        return on;
    endfunction

    function automatic bit exp_px(int x, int y);
        int dx, dy, d, g;
        dx = x - tlx;
        dy = y - tly;
        if (dx < 0 || dy < 0 || dx >= ND*DW || dy >= DH) return 1'b0;
        if (m_blink && ((m_frames / BF) % 2) == 1) return 1'b0;
        d = dx / DW;
        g = m_disp[d];
        if (m_blank && d < ND-1) begin
            bit lead;
            lead = 1'b1;
            for (int j = 0; j <= d; j++) if (m_disp[j] != 0) lead = 1'b0;
            if (lead) g = 10;
        end
        return glyph_px(g, dx % DW, dy);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input string tag, input int x, input int y);
        bit e;
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        exp_q.push_back(exp_px(x, y));
        tick();
        e = exp_q.pop_front();
        check(tag, 32'(bus.drawingRequest), 32'(e));
    endtask

    task automatic check_field(input string tag);
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < 8; k++)
                px($sformatf("%s_d%0d_p%0d", tag, d, k), tlx + d*DW + PCX[k], tly + PCY[k]);
    endtask

    task automatic set_tl(input int x, input int y);
        tlx = x;
        tly = y;
        bus.topLeftX = 11'(x);
        bus.topLeftY = 11'(y);
    endtask

    task automatic load(input int v, input bit replaces_pending);
        bus.score       = SW'(v);
        bus.score_valid = 1'b1;
        tick();
        bus.score_valid = 1'b0;
        if (replaces_pending && conv_q.size() > 0) conv_q[conv_q.size()-1] = v;
        else conv_q.push_back(v);
    endtask

    task automatic wait_idle(input string tag);
        int n, v, p;
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
        while (conv_q.size() > 0) begin
            v = conv_q.pop_front();
            p = 1;
            for (int d = ND-1; d >= 0; d--) begin
                m_shadow[d] = (v > 999999) ? 9 : (v / p) % 10;
                p = p * 10;
            end
            m_rdy = 1'b1;
        end
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        m_frames++;
        if (m_rdy) begin
            m_disp = m_shadow;
            m_rdy  = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        resetN = 1'b0;
        #2;
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_draw"}, 32'(bus.drawingRequest), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        for (int d = 0; d < ND; d++) begin
            m_disp[d]   = 0;
            m_shadow[d] = 0;
        end
        m_rdy    = 1'b0;
        m_frames = 0;
        conv_q.delete();
        tick();
    endtask

    initial begin
        int n;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.startOfFrame = 1'b0;
        bus.score = '0;
        bus.score_valid = 1'b0;
        bus.blank_leading_zeros = 1'b0;
        bus.blink_en = 1'b0;
        m_blank = 1'b0;
        m_blink = 1'b0;
        set_tl(100, 50);
        for (int d = 0; d < ND; d++) begin
            m_disp[d]   = 0;
            m_shadow[d] = 0;
        end
        m_rdy    = 1'b0;
        m_frames = 0;

        // Power-on reset
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_draw", 32'(bus.drawingRequest), 32'd0);
        check("rst_rgb", 32'(bus.RGBout), 32'hFF);
        @(negedge clk);
        resetN = 1'b1;
        tick();
        check_field("rst_zero");

        // Reset in the middle of a conversion
        load(123456, 1'b0);
        repeat (4) tick();
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        do_reset("midrst");
        sof();
        check_field("midrst_zero");

        // Normal conversion: busy spans SHIFT + DONE, display waits for frame start
        load(123456, 1'b0);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("busy_len", 32'(n), 32'(SW + 1));
        wait_idle("idle_123456");
        check_field("pre_sof");
        sof();
        check_field("d123456");
        px("glyph3_r0_c7", tlx + DW*2 + 7, tly);
        check("rgb_const", 32'(bus.RGBout), 32'hFF);

        // Saturation: over-range score shows all nines after two cycles
        load(1048575, 1'b0);
        check("sat_busy_c1", 32'(bus.busy), 32'd1);
        tick();
        check("sat_busy_c2", 32'(bus.busy), 32'd0);
        wait_idle("idle_sat");
        sof();
        check_field("d999999");

        // Leading-zero blanking
        bus.blank_leading_zeros = 1'b1;
        m_blank = 1'b1;
        load(42, 1'b0);
        wait_idle("idle_42");
        sof();
        check_field("lz42");
        load(0, 1'b0);
        wait_idle("idle_0");
        sof();
        check_field("lz0");
        bus.blank_leading_zeros = 1'b0;
        m_blank = 1'b0;

        // Strobes during a conversion: 200 is overwritten by 300 in the pending slot
        load(100, 1'b0);
        repeat (3) tick();
        load(200, 1'b0);
        tick();
        load(300, 1'b1);
        wait_idle("idle_ow");
        sof();
        check_field("ow300");

        // Moved field and edges
        set_tl(200, 100);
        check_field("moved");
        px("left_of_tl", 199, 110);
        px("above_tl", 210, 99);
        px("right_edge", 200 + ND*DW, 101);
        px("below_edge", 200 + 5*DW + 7, 100 + DH);
        px("last_row", 200 + 5*DW + 7, 100 + DH - 1);
        px("first_col_lit", 200 + 2, 100 + 8);
        set_tl(2000, 2000);
        px("tl_beyond", 5, 5);
        set_tl(100, 50);

        // Blink with BLINK_FRAMES=2: frames 0-1 on, 2-3 off, 4-5 on
        do_reset("blkrst");
        bus.blink_en = 1'b1;
        m_blink = 1'b1;
        for (int f = 0; f < 6; f++) begin
            px($sformatf("blink_f%0d", f), tlx + 7, tly + 1);
            px($sformatf("blink_f%0d_b", f), tlx + 3*DW + 3, tly + 22);
            sof();
        end
        sof();
        px("blink_f7_dark", tlx + 7, tly + 1);
        bus.blink_en = 1'b0;
        m_blink = 1'b0;
        px("blink_off_vis", tlx + 7, tly + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
